gcd_arbiter: RTL and testbench
==============================

# gcd_arbiter

Round-robin arbiter and sequencer that shares one GCD engine between `N_REQ` requesters. It accepts operand pairs from requesters and launches the shared engine with a one-cycle start pulse. It waits for the engine's done, then returns the result to the granted requester. It also handles zero operands locally and aborts hung operations with a watchdog.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand/result width.
- `TIMEOUT`, 1024: max WAIT cycles before abort, ≥4.
- `clk`  in  1  clock; the engine runs on the same clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `req_a`  in  N_REQ*WIDTH  operand a, slice i belongs to requester i.
- `req_b`  in  N_REQ*WIDTH  operand b, slice i belongs to requester i.
- `gnt`  out  N_REQ  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle response pulse.
- `rsp_result`  out  WIDTH  result, valid with rsp_valid.
- `rsp_timeout`  out  1  high with rsp_valid when the op was aborted.
- `busy`  out  1  high whenever state ≠ IDLE.
- `eng_start`  out  1  one-cycle engine start pulse.
- `eng_a`, `eng_b`  out  WIDTH  latched operands, stable from LAUNCH until IDLE.
- `eng_result`  in  WIDTH  engine result.
- `eng_done`  in  1  engine completion flag.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP. All outputs are registered. All outputs reset to 0, the state resets to IDLE, and the round-robin pointer `ptr` resets to 0.
- `req` is sampled only in IDLE. The grant goes to the first asserted bit scanning `ptr`, `ptr+1`, … with wrap modulo N_REQ. On grant, `ptr` becomes the granted index +1 mod N_REQ. The operands of the granted requester are latched into eng_a/eng_b and its id is stored.
- IDLE→LAUNCH when a grant is issued and both operands are nonzero.
- IDLE→RESP directly (bypass) when either operand is 0:
  - result = a|b, so 0,0 gives 0.
  - The engine is never started.
- LAUNCH lasts 1 cycle with eng_start=1, then goes to WAIT. The watchdog counter clears on entry to WAIT.
- WAIT:
  - eng_done is ignored in the first WAIT cycle, to mask a stale done.
  - From the second cycle on, eng_done=1 captures eng_result and goes to RESP with rsp_timeout=0.
  - The counter increments each WAIT cycle. When the counter reaches TIMEOUT-1 without done, go to RESP with rsp_result=0 and rsp_timeout=1.
  - If done and timeout occur in the same cycle, done wins.
- RESP lasts 1 cycle: rsp_valid[id]=1 with rsp_result and rsp_timeout, then back to IDLE.
- A requester must drop `req` in the cycle after it sees gnt. A held `req` is treated as a new request in the next IDLE.
- Requests arriving in non-IDLE states wait. There is no queueing beyond the req level.
- Reset mid-operation returns to IDLE immediately. No response is issued, eng_start is deasserted, and `ptr` returns to 0.

## Timing
- Cycle 0: IDLE with req seen.
- Cycle 1: gnt=1 and busy=1. The state is LAUNCH (eng_start=1), or RESP for bypass (rsp_valid=1 in the same cycle as gnt).
- Normal path: done first honoured in cycle 3. The response appears 1 cycle after the honoured done. Back to IDLE the cycle after RESP.
- Minimum launched-op turnaround is 5 cycles, request to next IDLE sample. Bypass turnaround is 2 cycles.
- Timeout response appears in cycle 2+TIMEOUT.

## Test plan
- Single requester 1, a=48, b=18 → gnt[1] in cycle 1, eng_start in cycle 1, engine done → rsp_valid[1], rsp_result=6, rsp_timeout=0.
- All four req high at once, ptr=0, distinct operands → grant order 0,1,2,3. Each rsp_valid matches its own gcd. Then re-request from 0 and 3 only → 0 is granted first.
- Requester 2 with a=0, b=35 → gnt[2] and rsp_valid[2] both in cycle 1, rsp_result=35, eng_start never asserted. With a=0, b=0 → rsp_result=0.
- Engine stub never asserts done, TIMEOUT=16 → rsp_valid with rsp_timeout=1 and rsp_result=0 in cycle 18, then the next request is serviced normally.
- eng_done held high from the previous op during the first WAIT cycle → ignored; result is taken from the later done. Done and timeout on the same cycle → rsp_timeout=0.
- reset_n pulsed low during WAIT → all outputs 0 asynchronously, no rsp_valid, and the arbiter grants a fresh request from ptr=0 after release.

Source files
------------

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one GCD engine between N_REQ requesters.
// Zero operands are answered locally and hung engine operations are aborted by a watchdog.
module gcd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_timeout,
    output logic                   busy,
    output logic                   eng_start,
    output logic [WIDTH-1:0]       eng_a,
    output logic [WIDTH-1:0]       eng_b,
    input  logic [WIDTH-1:0]       eng_result,
    input  logic                   eng_done
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               busy_q, busy_d;
    logic               eng_start_q, eng_start_d;
    logic [WIDTH-1:0]   eng_a_q, eng_a_d;
    logic [WIDTH-1:0]   eng_b_q, eng_b_d;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   scan_idx;
    logic [WIDTH-1:0]   sel_a, sel_b;

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // First asserted request at or after ptr_q, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && req[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
            scan_idx = (scan_idx == PTR_LAST) ? '0 : scan_idx + PTR_W'(1);
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        gnt_d         = '0;
        rsp_valid_d   = '0;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = 1'b0;
        eng_start_d   = 1'b0;
        eng_a_d       = eng_a_q;
        eng_b_d       = eng_b_q;

        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    ptr_d   = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
                    id_d    = grant_idx;
                    eng_a_d = sel_a;
                    eng_b_d = sel_b;
                    gnt_d   = onehot(grant_idx);
                    if (sel_a == '0 || sel_b == '0) begin
                        state_d      = RESP;
                        rsp_valid_d  = onehot(grant_idx);
                        rsp_result_d = sel_a | sel_b;
                    end else begin
                        state_d     = LAUNCH;
                        eng_start_d = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // cnt_q == 0 marks the first WAIT cycle, where a done left over from before is masked.
                if (eng_done && cnt_q != '0) begin
                    state_d      = RESP;
                    rsp_valid_d  = onehot(id_q);
                    rsp_result_d = eng_result;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = RESP;
                    rsp_valid_d   = onehot(id_q);
                    rsp_result_d  = '0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            id_q          <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            eng_start_q   <= 1'b0;
            eng_a_q       <= '0;
            eng_b_q       <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            eng_start_q   <= eng_start_d;
            eng_a_q       <= eng_a_d;
            eng_b_q       <= eng_b_d;
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;
    assign eng_start   = eng_start_q;
    assign eng_a       = eng_a_q;
    assign eng_b       = eng_b_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: a stub GCD engine, a cycle model built from the
// request/response timing rules, and hand-computed per-transaction expectations.
module tb_gcd_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;
    localparam logic [W-1:0] STALE_VAL = 32'd999;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   gnt, rsp_valid;
    logic [W-1:0]   rsp_result;
    logic           rsp_timeout, busy, eng_start;
    logic [W-1:0]   eng_a, eng_b, eng_result;
    logic           eng_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Engine stub controls
    int           eng_lat    = 2;
    logic         eng_hang   = 1'b0;
    logic         eng_stale  = 1'b0;
    int           eng_cnt    = 0;
    int           stale_left = 0;
    logic [W-1:0] eng_pend   = '0;

    logic [W-1:0] grp_a   [N] = '{32'd48, 32'd100, 32'd21, 32'd17};
    logic [W-1:0] grp_b   [N] = '{32'd18, 32'd75,  32'd14, 32'd5};
    logic [W-1:0] grp_gcd [N] = '{32'd6,  32'd25,  32'd7,  32'd1};

    gcd_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_result (eng_result),
        .eng_done   (eng_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Engine stub: done arrives eng_lat cycles after the start cycle; optional stale done
    // spanning the start cycle and the cycle after it; optional hang.
    initial begin
        eng_done   = 1'b0;
        eng_result = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done   = 1'b1;
                    eng_result = eng_pend;
                end
            end
            if (stale_left > 0) begin
                stale_left--;
                eng_done   = 1'b1;
                eng_result = STALE_VAL;
            end
            if (eng_start) begin
                if (!eng_hang) begin
                    eng_cnt  = eng_lat;
                    eng_pend = gcd(eng_a, eng_b);
                end
                if (eng_stale) begin
                    eng_done   = 1'b1;
                    eng_result = STALE_VAL;
                    stale_left = 1;
                end
            end
        end
    end

    // Cycle model: a grant in cycle g either answers in g (zero operand) or, for a launched op,
    // answers one cycle after the first done seen in g+2..g+TO, else in g+TO+1 with timeout.
    typedef enum {M_IDLE, M_RUN, M_RESP} mphase_t;
    mphase_t      m_phase = M_IDLE;
    int           m_ptr   = 0;
    int           m_id    = 0;
    int           m_k     = 0;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_b     = '0;
    logic [N-1:0] exp_gnt = '0, exp_rv = '0;
    logic         exp_start = 1'b0, exp_busy = 1'b0, exp_to = 1'b0;
    logic [W-1:0] exp_res = '0;

    initial begin
        int  win;
        bit  found;
        wait (reset_n === 1'b1);
        forever begin
            @(posedge clk or negedge reset_n);
            exp_gnt   = '0;
            exp_rv    = '0;
            exp_start = 1'b0;
            if (!reset_n) begin
                m_phase  = M_IDLE;
                m_ptr    = 0;
                m_a      = '0;
                m_b      = '0;
                exp_busy = 1'b0;
            end else begin
                case (m_phase)
                    M_IDLE: begin
                        exp_busy = 1'b0;
                        found    = 0;
                        win      = 0;
                        for (int i = 0; i < N; i++) begin
                            int w;
                            w = (m_ptr + i) % N;
                            if (!found && req[w]) begin
                                found = 1;
                                win   = w;
                            end
                        end
                        if (found) begin
                            m_ptr    = (win + 1) % N;
                            m_id     = win;
                            m_a      = req_a[win*W +: W];
                            m_b      = req_b[win*W +: W];
                            exp_gnt  = N'(1) << win;
                            exp_busy = 1'b1;
                            if (m_a == '0 || m_b == '0) begin
                                exp_rv  = N'(1) << win;
                                exp_res = m_a | m_b;
                                exp_to  = 1'b0;
                                m_phase = M_RESP;
                            end else begin
                                exp_start = 1'b1;
                                m_k       = 0;
                                m_phase   = M_RUN;
                            end
                        end
                    end
                    M_RUN: begin
                        exp_busy = 1'b1;
                        if (m_k >= 2 && eng_done) begin
                            exp_rv  = N'(1) << m_id;
                            exp_res = gcd(m_a, m_b);
                            exp_to  = 1'b0;
                            m_phase = M_RESP;
                        end else if (m_k == TO) begin
                            exp_rv  = N'(1) << m_id;
                            exp_res = '0;
                            exp_to  = 1'b1;
                            m_phase = M_RESP;
                        end
                        m_k++;
                    end
                    default: begin
                        exp_busy = 1'b0;
                        m_phase  = M_IDLE;
                    end
                endcase
            end
            #1;
            check("m_gnt", gnt, exp_gnt);
            check("m_rsp_valid", rsp_valid, exp_rv);
            check("m_eng_start", eng_start, exp_start);
            check("m_busy", busy, exp_busy);
            check("m_eng_a", eng_a, m_a);
            check("m_eng_b", eng_b, m_b);
            if (exp_rv != '0) begin
                check("m_rsp_result", rsp_result, exp_res);
                check("m_rsp_timeout", rsp_timeout, exp_to);
            end
        end
    end

    // One request; delays are counted from the cycle in which req is first visible.
    task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input logic hang, input logic stale,
                          input logic [W-1:0] x_res, input logic x_to, input logic x_start,
                          input int x_rdly, input string nm);
        int           c0, gc, rc;
        bit           started;
        logic [N-1:0] rv;
        logic [W-1:0] res;
        logic         to;
        @(negedge clk);
        eng_lat   = lat;
        eng_hang  = hang;
        eng_stale = stale;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req[idx]  = 1'b1;
        c0 = cyc; gc = -1; rc = -1; started = 0;
        rv = '0; res = '0; to = 1'b0;
        for (int n = 0; n < 200 && rc < 0; n++) begin
            @(negedge clk);
            if (gnt != '0 && gc < 0) begin
                gc = cyc;
                req[idx] = 1'b0;
            end
            if (eng_start) started = 1;
            if (rsp_valid != '0) begin
                rc  = cyc;
                rv  = rsp_valid;
                res = rsp_result;
                to  = rsp_timeout;
            end
        end
        req[idx] = 1'b0;
        check({nm, "_gnt_cycle"}, gc - c0, 1);
        check({nm, "_eng_start_seen"}, started, x_start);
        check({nm, "_rsp_cycle"}, rc - c0, x_rdly);
        check({nm, "_rsp_valid"}, rv, N'(1) << idx);
        check({nm, "_rsp_result"}, res, x_res);
        check({nm, "_rsp_timeout"}, to, x_to);
    endtask

    // Several requests at once; ord holds the expected grant sequence, one nibble per grant.
    task automatic run_group(input logic [N-1:0] mask, input logic [15:0] ord, input int cnt,
                             input string nm);
        int gi, ri, g;
        @(negedge clk);
        eng_lat   = 2;
        eng_hang  = 1'b0;
        eng_stale = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req_a[i*W +: W] = grp_a[i];
                req_b[i*W +: W] = grp_b[i];
            end
        end
        req = req | mask;
        gi = 0;
        ri = 0;
        for (int n = 0; n < 200 && ri < cnt; n++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g = oh2idx(gnt);
                if (gi < cnt) check($sformatf("%s_order%0d", nm, gi), g, int'(ord[gi*4 +: 4]));
                req[g] = 1'b0;
                gi++;
            end
            if (rsp_valid != '0) begin
                g = oh2idx(rsp_valid);
                check($sformatf("%s_result_req%0d", nm, g), rsp_result, grp_gcd[g]);
                check($sformatf("%s_timeout_req%0d", nm, g), rsp_timeout, 1'b0);
                ri++;
            end
        end
        req = req & ~mask;
        check({nm, "_grants"}, gi, cnt);
        check({nm, "_responses"}, ri, cnt);
    endtask

    initial begin
        bit rv_seen;
        bit got;
        reset_n = 1'b0;
        req     = '0;
        req_a   = '0;
        req_b   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_gnt", gnt, '0);
        check("reset_eng_start", eng_start, 1'b0);
        check("reset_eng_a", eng_a, '0);
        reset_n = 1'b1;

        run_group(4'b1111, 16'h3210, 4, "all4");
        run_group(4'b1001, 16'h0030, 2, "re03");

        run_op(1, 32'd48, 32'd18, 2, 1'b0, 1'b0, 32'd6, 1'b0, 1'b1, 4, "single1");

        run_op(2, 32'd0,  32'd35, 2, 1'b0, 1'b0, 32'd35, 1'b0, 1'b0, 1, "byp_0_35");
        run_op(2, 32'd0,  32'd0,  2, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1, "byp_0_0");
        run_op(2, 32'd35, 32'd0,  2, 1'b0, 1'b0, 32'd35, 1'b0, 1'b0, 1, "byp_35_0");

        run_op(0, 32'd12, 32'd8, 2, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 2 + TO, "timeout");
        run_op(0, 32'd12, 32'd8, 2, 1'b0, 1'b0, 32'd4, 1'b0, 1'b1, 4, "after_to");

        run_op(1, 32'd48, 32'd18, 3,  1'b0, 1'b1, 32'd6,  1'b0, 1'b1, 5,      "stale");
        run_op(3, 32'd81, 32'd27, TO, 1'b0, 1'b0, 32'd27, 1'b0, 1'b1, 2 + TO, "done_at_to");

        // Abort an operation sitting in WAIT with an asynchronous reset.
        @(negedge clk);
        eng_hang  = 1'b1;
        eng_stale = 1'b0;
        req_a[2*W +: W] = 32'd30;
        req_b[2*W +: W] = 32'd12;
        req[2] = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (gnt[2]) got = 1;
        end
        req[2] = 1'b0;
        check("rst_gnt_seen", got, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_busy_before", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_gnt", gnt, '0);
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_eng_a", eng_a, '0);
        check("rst_eng_b", eng_b, '0);
        check("rst_rsp_result", rsp_result, '0);
        rv_seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (rsp_valid != '0) rv_seen = 1;
        end
        check("rst_no_rsp", rv_seen, 1'b0);
        @(negedge clk);
        reset_n  = 1'b1;
        eng_hang = 1'b0;
        run_group(4'b1010, 16'h0031, 2, "after_rst");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_watchdog: got time %0t expected completion before it", $time);
        $fatal(1, "bench did not complete");
    end

endmodule
